// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage MIPS pipeline: word/register types, opcode and
// funct encodings, and the IF/ID and ID/EX latch bundles.
package cpu_types_pkg;

  localparam int         REGS    = 32;
  localparam int         REG_W   = $clog2(REGS);
  localparam logic [5:0] HALT_OP = 6'h3F;

  typedef logic [31:0]      word_t;
  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = HALT_OP
  } opcode_t;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00,
    F_SRL  = 6'h02,
    F_JR   = 6'h08,
    F_ADD  = 6'h20,
    F_ADDU = 6'h21,
    F_SUB  = 6'h22,
    F_SUBU = 6'h23,
    F_AND  = 6'h24,
    F_OR   = 6'h25,
    F_XOR  = 6'h26,
    F_NOR  = 6'h27,
    F_SLT  = 6'h2A,
    F_SLTU = 6'h2B
  } funct_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t npc;
  } fetch_latch_t;

  typedef struct packed {
    logic     valid;
    word_t    instr;
    word_t    npc;
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    regbits_t wsel;
    logic     regwr;
    logic     memread;
    logic     memwrite;
    logic     halt;
  } decode_latch_t;

endpackage

// File: rtl/register_file.sv
// 32x32 architectural register file: r0 hardwired to zero, two combinational
// read ports with write-before-read bypass from the single write port.
module register_file
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             WEN,
  input  logic [REG_W-1:0] wsel,
  input  logic [31:0]      wdat,
  input  logic [REG_W-1:0] rsel1,
  input  logic [REG_W-1:0] rsel2,
  output logic [31:0]      rdat1,
  output logic [31:0]      rdat2
);

  word_t r_regs [REGS];

  // NOTE: the array is reset because architectural state must read as zero
  // after nRST; sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
    end else if (WEN && (wsel != '0)) begin
      r_regs[wsel] <= wdat;
    end
  end

  // NOTE: each output is assigned first thing so no path can infer a latch.
  always_comb begin
    rdat1 = r_regs[rsel1];
    if (rsel1 == '0)                       rdat1 = '0;
    else if (WEN && (wsel == rsel1))       rdat1 = wdat;
  end

  always_comb begin
    rdat2 = r_regs[rsel2];
    if (rsel2 == '0)                       rdat2 = '0;
    else if (WEN && (wsel == rsel2))       rdat2 = wdat;
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: register read with writeback bypass, immediate extension, control
// decode, load-use hazard detection and the ID/EX pipeline latch.
module decode_stage
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             flush,
  input  logic             fl_valid,
  input  logic [31:0]      fl_instr,
  input  logic [31:0]      fl_npc,
  input  logic             wb_regwr,
  input  logic [REG_W-1:0] wb_wsel,
  input  logic [31:0]      wb_wdat,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wsel,
  output logic             hazard_stall,
  output logic             dl_valid,
  output logic [31:0]      dl_instr,
  output logic [31:0]      dl_npc,
  output logic [31:0]      dl_rdat1,
  output logic [31:0]      dl_rdat2,
  output logic [31:0]      dl_imm,
  output logic [REG_W-1:0] dl_wsel,
  output logic             dl_regwr,
  output logic             dl_memread,
  output logic             dl_memwrite,
  output logic             dl_halt
);

  opcode_t       w_op;
  funct_t        w_funct;
  regbits_t      w_rs, w_rt, w_rd;
  logic [15:0]   w_imm16;
  word_t         w_rdat1, w_rdat2;
  logic          w_uses_rt;
  decode_latch_t w_next;
  decode_latch_t r_dl;

  assign w_op    = opcode_t'(fl_instr[31:26]);
  assign w_funct = funct_t'(fl_instr[5:0]);
  assign w_rs    = fl_instr[25:21];
  assign w_rt    = fl_instr[20:16];
  assign w_rd    = fl_instr[15:11];
  assign w_imm16 = fl_instr[15:0];

  register_file u_regfile (
    .CLK   (CLK),
    .nRST  (nRST),
    .WEN   (wb_regwr),
    .wsel  (wb_wsel),
    .wdat  (wb_wdat),
    .rsel1 (w_rs),
    .rsel2 (w_rt),
    .rdat1 (w_rdat1),
    .rdat2 (w_rdat2)
  );

  always_comb begin
    w_next       = '0;
    w_uses_rt    = 1'b0;
    w_next.valid = fl_valid;
    w_next.instr = fl_instr;
    w_next.npc   = fl_npc;
    w_next.rdat1 = w_rdat1;
    w_next.rdat2 = w_rdat2;
    w_next.imm   = {{16{w_imm16[15]}}, w_imm16};
    w_next.wsel  = w_rt;
    case (w_op)
      OP_RTYPE: begin
        w_next.wsel  = w_rd;
        w_next.regwr = (w_funct != F_JR);
        w_uses_rt    = 1'b1;
      end
      OP_JAL: begin
        w_next.wsel  = regbits_t'(REGS - 1);
        w_next.regwr = 1'b1;
      end
      OP_BEQ, OP_BNE: w_uses_rt = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: w_next.regwr = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_next.regwr = 1'b1;
        w_next.imm   = {16'h0, w_imm16};
      end
      OP_LUI: begin
        w_next.regwr = 1'b1;
        w_next.imm   = {w_imm16, 16'h0};
      end
      OP_LW: begin
        w_next.regwr   = 1'b1;
        w_next.memread = 1'b1;
      end
      OP_SW: begin
        w_next.memwrite = 1'b1;
        w_uses_rt       = 1'b1;
      end
      OP_HALT: w_next.halt = 1'b1;
      default: ;
    endcase
  end

  assign hazard_stall = fl_valid & ex_memread & (ex_wsel != '0) &
                        ((ex_wsel == w_rs) | (w_uses_rt & (ex_wsel == w_rt)));

  // A squashed, stalled or empty slot becomes an all-zero bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dl <= '0;
    end else if (en) begin
      if (flush || hazard_stall || !fl_valid) r_dl <= '0;
      else                                    r_dl <= w_next;
    end
  end

  assign dl_valid    = r_dl.valid;
  assign dl_instr    = r_dl.instr;
  assign dl_npc      = r_dl.npc;
  assign dl_rdat1    = r_dl.rdat1;
  assign dl_rdat2    = r_dl.rdat2;
  assign dl_imm      = r_dl.imm;
  assign dl_wsel     = r_dl.wsel;
  assign dl_regwr    = r_dl.regwr;
  assign dl_memread  = r_dl.memread;
  assign dl_memwrite = r_dl.memwrite;
  assign dl_halt     = r_dl.halt;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
ID stage of the 5-stage MIPS pipeline. Consumes the IF/ID latch from the fetch stage and reads the register file, with write-before-read bypass of the writeback port. Sign/zero-extends immediates, decodes control fields and detects load-use hazards. Registers everything into the ID/EX latch consumed by the execute stage; owns the 32x32 register file.

Parameters:
REGS, 32, number of architectural registers (index width = log2(REGS) = 5)
HALT_OP, 6'h3F, opcode that sets the halt flag

Ports:
CLK  input  1  system clock, rising-edge
nRST  input  1  asynchronous active-low reset
en  input  1  pipeline advance (ihit/dhit-qualified); 0 = hold all state except regfile writes
flush  input  1  squash ID/EX contents (branch/jump resolved taken)
fl_valid  input  1  IF/ID latch holds a real instruction
fl_instr  input  32  instruction word from IF/ID
fl_npc  input  32  PC+4 from IF/ID
wb_regwr  input  1  writeback enable
wb_wsel  input  5  writeback register index
wb_wdat  input  32  writeback data
ex_memread  input  1  instruction currently in EX is a load
ex_wsel  input  5  destination of instruction in EX
hazard_stall  output  1  load-use hazard; fetch must hold IF/ID and PC
dl_valid  output  1  ID/EX holds a real instruction
dl_instr  output  32  registered instruction
dl_npc  output  32  registered PC+4
dl_rdat1  output  32  rs value
dl_rdat2  output  32  rt value
dl_imm  output  32  extended immediate
dl_wsel  output  5  destination register (rd for R-type, 31 for JAL, else rt)
dl_regwr  output  1  writes a register
dl_memread  output  1  load
dl_memwrite  output  1  store
dl_halt  output  1  HALT reached this stage

Behaviour:
- Reset (nRST=0, async): all dl_* = 0, all registers = 0; hazard_stall = 0 while fl_valid=0.
- Register file: written on rising CLK when wb_regwr=1 and wb_wsel!=0, independent of en. Reg 0 reads 0 always. Read is combinational; if wb_regwr=1, wb_wsel!=0 and wb_wsel equals the read index, return wb_wdat (bypass).
- Immediate: ANDI/ORI/XORI zero-extend imm16. LUI gives {imm16,16'h0}. All other I-types sign-extend. R/J-types: dl_imm = sign-extended low 16 bits (don't-care).
- Control: R-type (op 0) regwr=1 except JR. LW: regwr=1, memread=1. SW: memwrite=1. BEQ/BNE/J/JR: regwr=0. JAL: regwr=1, wsel=31. HALT_OP: halt=1, regwr=0. Unknown opcode: all control 0.
- Hazard: hazard_stall = fl_valid & ex_memread & (ex_wsel!=0) & (ex_wsel==rs | (uses_rt & ex_wsel==rt)). uses_rt is true for R-type, BEQ, BNE and SW. Combinational, same cycle.
- ID/EX update on rising CLK, priority: en=0 -> hold all. Else flush=1 -> bubble. Else hazard_stall=1 -> bubble. Else load decoded values, dl_valid=fl_valid.
- Bubble: dl_valid, dl_regwr, dl_memread, dl_memwrite and dl_halt = 0. Data fields are don't-care (implement as 0).
- fl_valid=0 with en=1: bubble.
- Latency: one cycle from fl_* to dl_*. A writeback and a read of the same register in one cycle returns the new value.
- Reset mid-operation clears the register file and the latch immediately; no pending state survives.

Decomposition:
- cpu_types_pkg gets: word_t, regbits_t, opcode_t and funct_t enums, and the decode_latch_t struct bundling the dl_* fields. The IF/ID latch type is already in the package.
- Sub-module register_file (CLK, nRST, WEN, wsel, wdat, rsel1, rsel2, rdat1, rdat2), including the bypass. decode_stage instantiates it plus the extend/control logic and the latch.

Test Plan:
- Reset then fl_instr=ADDIU r2,r0,-1 (0x2402FFFF), en=1: next cycle dl_imm=0xFFFFFFFF, dl_wsel=2, dl_regwr=1, dl_valid=1.
- ORI r3,r0,0x8000: dl_imm=0x00008000. LUI r4,0x1234: dl_imm=0x12340000.
- wb_regwr=1, wb_wsel=5, wb_wdat=0xDEADBEEF in the same cycle as ADDU r6,r5,r0: dl_rdat1=0xDEADBEEF. Write to r0 then read r0 -> 0.
- ex_memread=1, ex_wsel=7, fl_instr=ADDU r8,r7,r1: hazard_stall=1, next dl_valid=0. With ex_memread=0 next cycle: the instruction issues with the correct dl_wsel=8.
- flush=1 and hazard both asserted, en=1: bubble. en=0 with flush=1: dl_* unchanged.
- Assert nRST low mid-stream after writing r9=0x55: dl_*=0 asynchronously, and reading r9 afterwards gives 0.
